// File: rtl/deglitch_ctrl_pkg.sv
// Shared types for the I2C deglitch filter controller.
// State encoding and I2C speed-mode constants.
package dgf_pkg;

    typedef enum logic [2:0] {
        PRESET,
        SETTLE,
        ACTIVE,
        WAIT_IDLE,
        SWITCH
    } dgf_state_t;

    typedef logic [1:0] dgf_mode_t;

    localparam dgf_mode_t MODE_SM  = 2'd0;
    localparam dgf_mode_t MODE_FM  = 2'd1;
    localparam dgf_mode_t MODE_FMP = 2'd2;
    localparam dgf_mode_t MODE_HS  = 2'd3;

    // Only high-speed mode bypasses the analog filter.
    function automatic logic mode_byp(input dgf_mode_t m);
        return m == MODE_HS;
    endfunction

endpackage

// File: rtl/deglitch_ctrl_if.sv
// Mode request, status and filter-cell signal bundle.
// master = host/pad side, slave = controller.
interface deglitch_ctrl_if;
    import dgf_pkg::*;

    dgf_mode_t  mode_req;
    logic       mode_vld;
    logic       mode_ack;
    dgf_mode_t  mode_cur;
    logic       ready;
    logic       scl_out;
    logic       scl_dout;
    logic       sda_out;
    logic       sda_dout;
    logic       scl_sb;
    logic       sda_sb;
    logic       scl_byp;
    logic       sda_byp;
    logic [1:0] fault;
    logic       fault_clr;

    modport master (
        output mode_req, mode_vld, fault_clr,
        output scl_out, scl_dout, sda_out, sda_dout,
        input  mode_ack, mode_cur, ready,
        input  scl_sb, sda_sb, scl_byp, sda_byp, fault
    );

    modport slave (
        input  mode_req, mode_vld, fault_clr,
        input  scl_out, scl_dout, sda_out, sda_dout,
        output mode_ack, mode_cur, ready,
        output scl_sb, sda_sb, scl_byp, sda_byp, fault
    );

endinterface

// File: rtl/deglitch_ctrl_line_mon.sv
// Per-line monitor: synchronizes a filter cell's OUT/DOUT pair
// and strobes once when they disagree for STUCK_CYC cycles.
module dgf_line_mon #(
    parameter int STUCK_CYC = 128
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic out_a,
    input  logic dout_a,
    output logic out_s,
    output logic fault_set
);

    localparam int SW = $clog2(STUCK_CYC + 1);

    logic [1:0]    out_sync;
    logic [1:0]    dout_sync;
    logic [SW-1:0] cnt;
    logic          diff;

    // two-flop synchronizers for the asynchronous cell outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            out_sync  <= '0;
            dout_sync <= '0;
        end else begin
            out_sync  <= {out_sync[0], out_a};
            dout_sync <= {dout_sync[0], dout_a};
        end
    end

    assign out_s = out_sync[1];
    assign diff  = out_sync[1] ^ dout_sync[1];

    // saturating run length of consecutive OUT != DOUT cycles
    always_ff @(posedge clk) begin
        if (rst || !en || !diff) begin
            cnt <= '0;
        end else if (cnt != SW'(STUCK_CYC)) begin
            cnt <= cnt + SW'(1);
        end
    end

    // fires on the single cycle the run reaches STUCK_CYC
    assign fault_set = en && diff && (cnt == SW'(STUCK_CYC - 1));

endmodule

// File: rtl/deglitch_ctrl.sv
// Sequencer for the SCL/SDA analog deglitch filter cells.
// Optional macro DEGLITCH_CTRL_FAULT_BYP_EN: a faulted line is forced into bypass.
module deglitch_ctrl
    import dgf_pkg::*;
#(
    parameter int PRESET_CYC = 4,
    parameter int SETTLE_CYC = 64,
    parameter int IDLE_CYC   = 16,
    parameter int STUCK_CYC  = 128,
    parameter int CNT_W      = 8
) (
    input  logic            clk,
    input  logic            rst,
    deglitch_ctrl_if.slave  bus
);

    dgf_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             pend;
    dgf_mode_t        pend_mode;
    dgf_mode_t        mode_q;
    logic             byp_q;
    logic             from_sw;
    logic             ack_q;
    logic             ready_q;
    logic             sb_q;
    logic [1:0]       fault_q;
    logic             scl_s;
    logic             sda_s;
    logic             scl_set;
    logic             sda_set;
    logic             mon_en;

    assign mon_en = (state == ACTIVE) || (state == WAIT_IDLE);

    dgf_line_mon #(.STUCK_CYC(STUCK_CYC)) u_scl_mon (
        .clk       (clk),
        .rst       (rst),
        .en        (mon_en),
        .out_a     (bus.scl_out),
        .dout_a    (bus.scl_dout),
        .out_s     (scl_s),
        .fault_set (scl_set)
    );

    dgf_line_mon #(.STUCK_CYC(STUCK_CYC)) u_sda_mon (
        .clk       (clk),
        .rst       (rst),
        .en        (mon_en),
        .out_a     (bus.sda_out),
        .dout_a    (bus.sda_dout),
        .out_s     (sda_s),
        .fault_set (sda_set)
    );

    // preset/settle sequencing, request latch and idle-gated mode switch
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PRESET;
            cnt       <= '0;
            pend      <= 1'b0;
            pend_mode <= MODE_SM;
            mode_q    <= MODE_SM;
            byp_q     <= 1'b0;
            from_sw   <= 1'b0;
            ack_q     <= 1'b0;
            ready_q   <= 1'b0;
            sb_q      <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            unique case (state)
                PRESET: begin
                    if (cnt == CNT_W'(PRESET_CYC - 1)) begin
                        state <= SETTLE;
                        cnt   <= '0;
                        sb_q  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SETTLE: begin
                    if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
                        state   <= ACTIVE;
                        cnt     <= '0;
                        ready_q <= 1'b1;
                        ack_q   <= from_sw;
                        from_sw <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ACTIVE: begin
                    if (pend) begin
                        if (pend_mode == mode_q) begin
                            ack_q <= 1'b1;
                            pend  <= 1'b0;
                        end else begin
                            state <= WAIT_IDLE;
                            cnt   <= '0;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (!(scl_s && sda_s)) begin
                        cnt <= '0;
                    end else if (cnt == CNT_W'(IDLE_CYC - 1)) begin
                        state   <= SWITCH;
                        cnt     <= '0;
                        mode_q  <= pend_mode;
                        byp_q   <= mode_byp(pend_mode);
                        pend    <= 1'b0;
                        from_sw <= 1'b1;
                        ready_q <= 1'b0;
                        sb_q    <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SWITCH: begin
                    if (cnt == CNT_W'(PRESET_CYC - 1)) begin
                        state <= SETTLE;
                        cnt   <= '0;
                        sb_q  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= PRESET;
                    cnt   <= '0;
                    sb_q  <= 1'b0;
                end
            endcase
            // a fresh strobe always wins over any clear above
            if (bus.mode_vld) begin
                pend      <= 1'b1;
                pend_mode <= bus.mode_req;
            end
        end
    end

    // sticky per-line fault; a set in the clearing cycle survives
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= '0;
        end else begin
            fault_q <= (bus.fault_clr ? 2'b00 : fault_q) | {sda_set, scl_set};
        end
    end

    assign bus.scl_sb   = sb_q;
    assign bus.sda_sb   = sb_q;
    assign bus.ready    = ready_q;
    assign bus.mode_ack = ack_q;
    assign bus.mode_cur = mode_q;
    assign bus.fault    = fault_q;

`ifdef DEGLITCH_CTRL_FAULT_BYP_EN
    assign bus.scl_byp = byp_q | fault_q[0];
    assign bus.sda_byp = byp_q | fault_q[1];
`else
    assign bus.scl_byp = byp_q;
    assign bus.sda_byp = byp_q;
`endif

endmodule

// File: tb/tb_deglitch_ctrl.sv
// Directed bench for deglitch_ctrl with an ACK scoreboard.
// Expected modes are queued at request time and popped on MODE_ACK.
module tb_deglitch_ctrl;
    import dgf_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    deglitch_ctrl_if bus();

    deglitch_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks  = 0;
    int errors  = 0;
    int ack_cnt = 0;
    dgf_mode_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every ACK must match a queued request
    always @(negedge clk) begin
        if (bus.mode_ack === 1'b1) begin
            ack_cnt++;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_ack observed mode_cur %0d expected no ack",
                       bus.mode_cur);
            end
            if (exp_q.size() != 0) chk("ack_mode", bus.mode_cur, exp_q.pop_front());
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_sb"}, {bus.scl_sb, bus.sda_sb}, 0);
        chk({tag, "_byp"}, {bus.scl_byp, bus.sda_byp}, 0);
        chk({tag, "_ready"}, bus.ready, 0);
        chk({tag, "_ack"}, bus.mode_ack, 0);
        chk({tag, "_mode"}, bus.mode_cur, 0);
        chk({tag, "_fault"}, bus.fault, 0);
    endtask

    task automatic powerup(input string tag);
        int sb_at;
        int rdy_at;
        sb_at  = -1;
        rdy_at = -1;
        for (int i = 1; i <= 90; i++) begin
            @(negedge clk);
            if (sb_at < 0 && bus.scl_sb && bus.sda_sb) sb_at = i;
            if (rdy_at < 0 && bus.ready) rdy_at = i;
        end
        chk({tag, "_sb_rise"}, sb_at, 4);
        chk({tag, "_ready_rise"}, rdy_at, 68);
        chk({tag, "_mode"}, bus.mode_cur, 0);
    endtask

    task automatic wait_sb_low(output int n, input int bound);
        n = 0;
        do begin
            @(negedge clk);
            bus.mode_vld = 1'b0;
            n++;
        end while (bus.scl_sb && n < bound);
    endtask

    task automatic wait_ack(output int n, input int bound);
        n = 0;
        while (!bus.mode_ack && n < bound) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        int prev;
        int ack_at;
        logic ok;

        bus.mode_req  = MODE_SM;
        bus.mode_vld  = 1'b0;
        bus.fault_clr = 1'b0;
        bus.scl_out   = 1'b1;
        bus.scl_dout  = 1'b1;
        bus.sda_out   = 1'b1;
        bus.sda_dout  = 1'b1;

        // reset and power-up sequence
        repeat (3) @(negedge clk);
        chk_reset("rst");
        rst = 1'b0;
        powerup("pu");
        chk("pu_no_ack", ack_cnt, 0);

        // switch to Hs with an idle bus
        prev = ack_cnt;
        exp_q.push_back(MODE_HS);
        bus.mode_req = MODE_HS;
        bus.mode_vld = 1'b1;
        n  = 0;
        ok = 1'b1;
        do begin
            @(negedge clk);
            bus.mode_vld = 1'b0;
            n++;
            if (bus.scl_sb) ok &= bus.ready;
        end while (bus.scl_sb && n < 40);
        chk("hs_idle_lat", n, 18);
        chk("hs_ready_wait", ok, 1);
        chk("hs_byp", {bus.scl_byp, bus.sda_byp}, 2'b11);
        chk("hs_mode", bus.mode_cur, MODE_HS);
        chk("hs_ready_sw", bus.ready, 0);
        n = 1;
        @(negedge clk);
        while (!bus.scl_sb && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("hs_sb_low", n, 4);
        wait_ack(n, 100);
        chk("hs_ack_lat", n, 64);
        @(negedge clk);
        chk("hs_ack_pulse", bus.mode_ack, 0);
        repeat (3) @(negedge clk);
        chk("hs_ack_once", ack_cnt, prev + 1);

        // switch to Fm, held off by SDA activity
        exp_q.push_back(MODE_FM);
        bus.mode_req = MODE_FM;
        bus.mode_vld = 1'b1;
        ok = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            bus.mode_vld = 1'b0;
            ok &= bus.ready && bus.scl_sb;
            bus.sda_out  = (i % 10 != 0);
            bus.sda_dout = (i % 10 != 0);
        end
        bus.sda_out  = 1'b1;
        bus.sda_dout = 1'b1;
        chk("fm_busy_ready", ok, 1);
        chk("fm_busy_mode", bus.mode_cur, MODE_HS);
        wait_sb_low(n, 40);
        chk("fm_switch", bus.scl_sb, 0);
        chk("fm_byp", {bus.scl_byp, bus.sda_byp}, 2'b00);
        chk("fm_mode", bus.mode_cur, MODE_FM);
        wait_ack(n, 120);
        chk("fm_ack", bus.mode_ack, 1);
        repeat (3) @(negedge clk);

        // request for the mode already applied
        prev = ack_cnt;
        exp_q.push_back(MODE_FM);
        bus.mode_req = MODE_FM;
        bus.mode_vld = 1'b1;
        ack_at = -1;
        ok = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            bus.mode_vld = 1'b0;
            if (ack_at < 0 && bus.mode_ack) ack_at = i;
            ok &= bus.scl_sb && bus.sda_sb;
        end
        chk("same_ack_lat", ack_at, 2);
        chk("same_sb_high", ok, 1);
        chk("same_ack_once", ack_cnt, prev + 1);

        // stuck SCL delay chain, clear held through the set
        bus.fault_clr = 1'b1;
        bus.scl_dout  = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.fault[0] !== 1'b1 && n < 200);
        bus.fault_clr = 1'b0;
        chk("stuck_lat", n, 130);
        chk("stuck_fault", bus.fault, 2'b01);
        repeat (5) @(negedge clk);
        chk("stuck_sticky", bus.fault, 2'b01);
`ifdef DEGLITCH_CTRL_FAULT_BYP_EN
        chk("stuck_scl_byp", bus.scl_byp, 1);
`else
        chk("stuck_scl_byp", bus.scl_byp, 0);
`endif
        chk("stuck_sda_byp", bus.sda_byp, 0);
        bus.fault_clr = 1'b1;
        @(negedge clk);
        bus.fault_clr = 1'b0;
        @(negedge clk);
        chk("clr_fault", bus.fault, 2'b00);
        chk("clr_scl_byp", bus.scl_byp, 0);
        bus.scl_dout = 1'b1;
        repeat (4) @(negedge clk);

        // reset in the middle of a switch with a request pending
        prev = ack_cnt;
        bus.mode_req = MODE_FMP;
        bus.mode_vld = 1'b1;
        wait_sb_low(n, 40);
        chk("rs_in_switch", bus.scl_sb, 0);
        chk("rs_mode_fmp", bus.mode_cur, MODE_FMP);
        bus.mode_req = MODE_SM;
        bus.mode_vld = 1'b1;
        @(negedge clk);
        bus.mode_vld = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk_reset("rs");
        rst = 1'b0;
        powerup("rs_pu");
        repeat (20) @(negedge clk);
        chk("rs_no_ack", ack_cnt, prev);
        chk("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/deglitch_ctrl.md
Name: deglitch_ctrl

Overview:
- Clocked sequencer for the two analog deglitch filter cells on SCL and SDA in the I2C pad path.
- Drives each cell's active-low preset (SB) and bypass (BYP) controls.
- Runs the power-up preset/settle sequence and applies I2C speed-mode changes only while the bus is idle.
- Monitors each cell's OUT/DOUT pair to flag a broken delay chain.

Parameters:
PRESET_CYC, 4, cycles SB is held low per preset
SETTLE_CYC, 64, cycles waited after SB release for the delay chain to settle
IDLE_CYC, 16, consecutive cycles with SCL and SDA high that count as bus idle
STUCK_CYC, 128, consecutive OUT != DOUT cycles that set FAULT
CNT_W, 8, width of the shared sequence counter; must hold max(PRESET_CYC, SETTLE_CYC, IDLE_CYC)

Ports:
CLK  in  1  single clock
RST  in  1  synchronous reset, active-high
MODE_REQ  in  2  requested mode: 0 Sm, 1 Fm, 2 Fm+, 3 Hs
MODE_VLD  in  1  one-cycle request strobe
MODE_ACK  out  1  one-cycle pulse when the requested mode is in effect
MODE_CUR  out  2  mode currently applied
READY  out  1  filters settled, controller in ACTIVE
SCL_OUT, SCL_DOUT  in  1 each  SCL cell outputs, asynchronous
SDA_OUT, SDA_DOUT  in  1 each  SDA cell outputs, asynchronous
SCL_SB, SDA_SB  out  1 each  active-low latch preset
SCL_BYP, SDA_BYP  out  1 each  filter bypass
FAULT  out  2  sticky delay-chain fault: bit0 SCL, bit1 SDA
FAULT_CLR  in  1  clears FAULT

Behaviour:
- Reset values: SB=0 (both), BYP=0 (both), READY=0, MODE_ACK=0, MODE_CUR=0, FAULT=0. State=PRESET, counter=0, no request pending.
- All outputs are registered Moore decodes of the state and mode registers.
- States:
  - PRESET: SB=0. After PRESET_CYC cycles -> SETTLE.
  - SETTLE: SB=1. After SETTLE_CYC cycles -> ACTIVE.
  - ACTIVE: READY=1.
  - WAIT_IDLE: READY=1.
  - SWITCH: SB=0, READY=0. After PRESET_CYC cycles -> SETTLE.
- Sequence timing with default parameters, counting from the first cycle RST is low: SB rises at cycle 4 and READY rises at cycle 68.
- Request handling:
  - MODE_VLD is sampled in every state and latched as pending with its MODE_REQ.
  - A newer strobe overwrites the pending value.
  - Under RST, MODE_VLD is ignored.
- In ACTIVE with a request pending:
  - If the pending mode equals MODE_CUR: MODE_ACK pulses on the next cycle, the request is cleared, and the state stays ACTIVE.
  - Otherwise -> WAIT_IDLE.
- WAIT_IDLE:
  - The idle counter increments while synchronized SCL_OUT & SDA_OUT == 1 and clears on any low.
  - On reaching IDLE_CYC -> SWITCH.
  - A new strobe here updates the target without restarting the idle count.
- SWITCH entry (single cycle):
  - MODE_CUR <= pending mode.
  - BYP (both lines) <= (pending mode == 3).
  - Pending request cleared.
- SETTLE reached through SWITCH ends with a MODE_ACK pulse on the first ACTIVE cycle. The power-up SETTLE produces no ACK.
- Synchronization: all four cell inputs pass through 2-flop synchronizers. The idle and stuck logic use only synchronized values.
- Stuck monitor, per line:
  - Saturating counter of consecutive cycles with OUT != DOUT, active only in ACTIVE and WAIT_IDLE.
  - Cleared when OUT == DOUT and in every other state.
  - When the count reaches STUCK_CYC, the FAULT bit sets and stays set.
- FAULT clearing:
  - FAULT_CLR clears both bits.
  - If set and clear happen in the same cycle, set wins.
  - FAULT does not block mode switching.
- RST asserted mid-operation, in any state, returns everything to the reset values on the next edge. A pending request is discarded.

Optional Feature:
- Macro: DEGLITCH_CTRL_FAULT_BYP_EN.
- Defined: while a line's FAULT bit is 1, that line's BYP is forced to 1 regardless of mode, so signals pass through the latch unfiltered.
  - Clearing FAULT restores BYP to (MODE_CUR == 3) on the next cycle.
- Undefined: FAULT is status only and BYP depends on MODE_CUR alone.

Decomposition:
- Package dgf_pkg:
  - State enum {PRESET, SETTLE, ACTIVE, WAIT_IDLE, SWITCH}.
  - Mode constants MODE_SM=0, MODE_FM=1, MODE_FMP=2, MODE_HS=3.
- One sub-module, dgf_line_mon, instantiated per line:
  - 2-flop synchronizers for OUT and DOUT.
  - Stuck counter.
  - Outputs: synchronized OUT and a one-cycle fault-set strobe.
- The FSM, request latch and shared counter stay in the top module.

Test Plan:
- Reset release -> SB=0 for cycles 0-3, SB=1 at cycle 4, READY=1 at cycle 68, MODE_ACK never pulses, MODE_CUR=0.
- In ACTIVE, MODE_VLD with MODE_REQ=3 and both OUT high -> after 16 idle cycles, SB low for 4 cycles and BYP=1, MODE_CUR=3. MODE_ACK pulses exactly once, 64 cycles after SB release.
- Request for mode 1 while SDA_OUT toggles low every 10 cycles -> stays in WAIT_IDLE and READY stays 1. Once the toggling stops: switch after 16 idle cycles, BYP=0, ACK pulses.
- MODE_REQ equal to MODE_CUR -> MODE_ACK on the next cycle, SB never drops.
- SCL_DOUT held at 0 while SCL_OUT=1 -> FAULT=2'b01 after 128+sync cycles.
  - FAULT_CLR in the same cycle as the set -> FAULT stays set.
  - With DEGLITCH_CTRL_FAULT_BYP_EN defined, SCL_BYP=1.
- RST asserted during SWITCH with a request pending -> all outputs return to reset values, the power-up sequence restarts, and no ACK is issued.
